// File: rtl/states_pkg.sv
// Shared FSM state encodings and small elaboration helpers for the UART engines.
package states_pkg;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_e;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Signal bundle for one UART receive engine; the DUT modport is the engine's view.
interface uart_rx_IF #(
   parameter int DBIT = 8
);
   logic            clk;
   logic            rst_n;
   logic            s_tick;
   logic            rx;
   logic [DBIT-1:0] rx_dout;
   logic            rx_done;
   logic            frame_err;
   logic            parity_err;

   modport DUT (
      input  clk, rst_n, s_tick, rx,
      output rx_dout, rx_done, frame_err, parity_err
   );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit; 2 clk latency.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receive engine: oversampled start/data/stop recovery, one-clk rx_done strobe
// one clk after the last stop tick; no backpressure. Parity stage under UART_RX_PARITY_EN.
module uart_rx
   import states_pkg::*;
#(
   parameter int BIT_WIDTH  = 16,
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_tick,
   input  logic            rx,
   output logic [DBIT-1:0] rx_dout,
   output logic            rx_done,
   output logic            frame_err,
   output logic            parity_err
);

   // SB_TICK >= BIT_WIDTH, so the stop count sizes the shared tick counter.
   localparam int CW = cnt_width(SB_TICK);
   localparam int NW = cnt_width(DBIT);

   localparam logic [CW-1:0] HALF_LAST = CW'(BIT_WIDTH / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_WIDTH - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

   if (BIT_WIDTH < 4 || (BIT_WIDTH % 2) != 0 || SB_TICK < BIT_WIDTH || DBIT < 2 ||
       (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_cfg
      $error("uart_rx: unsupported parameter set");
   end

   logic            rx_s;
   rx_state_e       state, state_n;
   logic [CW-1:0]   s_cnt, s_cnt_n;
   logic [NW-1:0]   n_cnt, n_cnt_n;
   logic [DBIT-1:0] shift, shift_n;
   logic            stop_bad, stop_bad_n;
   logic            done_n;
`ifdef UART_RX_PARITY_EN
   localparam logic ODD = (PARITY_ODD != 0);
   logic            par_bit, par_bit_n;
`endif

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx),
      .q     (rx_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RX_IDLE;
         s_cnt    <= '0;
         n_cnt    <= '0;
         shift    <= '0;
         stop_bad <= 1'b0;
      end else begin
         state    <= state_n;
         s_cnt    <= s_cnt_n;
         n_cnt    <= n_cnt_n;
         shift    <= shift_n;
         stop_bad <= stop_bad_n;
      end
   end

   always_comb begin
      state_n    = state;
      s_cnt_n    = s_cnt;
      n_cnt_n    = n_cnt;
      shift_n    = shift;
      stop_bad_n = stop_bad;
      done_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_n  = par_bit;
`endif
      case (state)
         RX_IDLE: begin
            // The start edge is taken on any clk, not only on ticks.
            if (!rx_s) begin
               state_n = RX_START;
               s_cnt_n = '0;
            end
         end
         RX_START: begin
            if (s_tick) begin
               if (s_cnt == HALF_LAST) begin
                  if (!rx_s) begin
                     state_n = RX_DATA;
                     s_cnt_n = '0;
                     n_cnt_n = '0;
                  end else begin
                     state_n = RX_IDLE;
                  end
               end else begin
                  s_cnt_n = s_cnt + CW'(1);
               end
            end
         end
         RX_DATA: begin
            if (s_tick) begin
               if (s_cnt == BIT_LAST) begin
                  shift_n = {rx_s, shift[DBIT-1:1]};
                  s_cnt_n = '0;
                  if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_n = RX_PARITY;
`else
                     state_n = RX_STOP;
`endif
                  end else begin
                     n_cnt_n = n_cnt + NW'(1);
                  end
               end else begin
                  s_cnt_n = s_cnt + CW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         RX_PARITY: begin
            if (s_tick) begin
               if (s_cnt == BIT_LAST) begin
                  par_bit_n = rx_s;
                  s_cnt_n   = '0;
                  state_n   = RX_STOP;
               end else begin
                  s_cnt_n = s_cnt + CW'(1);
               end
            end
         end
`endif
         RX_STOP: begin
            if (s_tick) begin
               // With SB_TICK == BIT_WIDTH the stop sample and exit share one tick.
               if (s_cnt == BIT_LAST) begin
                  stop_bad_n = ~rx_s;
               end
               if (s_cnt == STOP_LAST) begin
                  state_n = RX_IDLE;
                  done_n  = 1'b1;
               end else begin
                  s_cnt_n = s_cnt + CW'(1);
               end
            end
         end
         default: state_n = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_done   <= 1'b0;
         rx_dout   <= '0;
         frame_err <= 1'b0;
      end else begin
         rx_done <= done_n;
         if (done_n) begin
            rx_dout   <= shift;
            frame_err <= stop_bad_n;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bit <= par_bit_n;
         if (done_n) begin
            parity_err <= ^shift ^ par_bit ^ ODD;
         end
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive engine. Oversamples the serial line rx using the shared baud tick s_tick, recovers start, data (LSB first) and stop bits, and presents the assembled word with a one-cycle rx_done strobe.
- Sits between the pad-side serial input and the RX FIFO write port. Mirror of the transmit engine and shares its parameterisation: BIT_WIDTH ticks per bit, DBIT data bits, SB_TICK stop ticks.

Parameters:
- BIT_WIDTH, 16: s_tick pulses per bit period; must be even and >= 4.
- DBIT, 8: data bits per frame.
- SB_TICK, 16: s_tick pulses spent in the stop phase; 16/24/32 give 1/1.5/2 stop bits; must be >= BIT_WIDTH.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even. Used only with UART_RX_PARITY_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- s_tick  in  1  baud oversample enable, one clk wide.
- rx  in  1  asynchronous serial line, idle high.
- rx_dout  out  DBIT  received word.
- rx_done  out  1  one-clk strobe: rx_dout, frame_err and parity_err are valid.
- frame_err  out  1  stop bit sampled low.
- parity_err  out  1  parity mismatch; constant 0 without the macro.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. Ports are carried on uart_rx_IF, modport DUT.
- Reset values: rx_dout=0, rx_done=0, frame_err=0, parity_err=0. Internally: state IDLE, s_cnt=0, n_cnt=0, shift reg=0, synchronizer flops=1.
- Synchronizer: rx passes through a 2-flop synchronizer, giving rx_s. All sampling uses rx_s. It adds 2 clk of input latency.
- Sampling rule: every state below advances only on cycles with s_tick=1. Counters hold when s_tick=0.
- IDLE:
  - rx_s=0 (independent of s_tick) -> START, s_cnt<=0.
- START (half-bit centring):
  - On s_tick with s_cnt==BIT_WIDTH/2-1: if rx_s==0 -> DATA, s_cnt<=0, n_cnt<=0. If rx_s==1 -> false start, back to IDLE, no strobe.
  - Otherwise s_cnt++.
- DATA:
  - On s_tick with s_cnt==BIT_WIDTH-1: shift reg <= {rx_s, shift[DBIT-1:1]} (LSB first), s_cnt<=0.
  - If n_cnt==DBIT-1 -> PARITY (macro on) or STOP; otherwise n_cnt++.
  - On other ticks s_cnt++.
- PARITY (macro only):
  - On s_tick with s_cnt==BIT_WIDTH-1: latch the parity sample, s_cnt<=0 -> STOP.
- STOP:
  - On s_tick with s_cnt==BIT_WIDTH-1: latch stop_bad = ~rx_s.
  - On s_tick with s_cnt==SB_TICK-1: go to IDLE and fire the output update. When SB_TICK==BIT_WIDTH both events happen on the same tick; the current rx_s is used directly.
  - Otherwise s_cnt++.
- Output update: registered, in the clk after the final STOP tick.
  - rx_done=1 for exactly one clk.
  - rx_dout <= shift reg, frame_err <= stop_bad, parity_err <= computed result.
  - rx_dout, frame_err and parity_err hold until the next update. Errored frames are still strobed.
- Back-to-back frames: IDLE re-arms in the same clk as the STOP exit. A start edge already low is accepted on the next clk.
- rx low for a whole frame (break): decoded as data 0 with frame_err=1, then receive restarts.
- Reset mid-frame: all state and outputs return to reset values immediately; the partial frame is discarded.
- s_tick stuck at 0: the FSM freezes in place; no timeout.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP, one bit period long. parity_err = (^data ^ parity_sample ^ PARITY_ODD) != 0, updated with rx_done.
- Undefined: no PARITY state, frames are data then stop, parity_err is tied 0.

Decomposition:
- Shared states_pkg gains rx_state_e {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP}.
- RX_PARITY is present in the enum regardless of the macro.
- A synchronous default case decodes any unused encoding as RX_IDLE.
- One sub-module: sync_2ff, a generic 2-flop bit synchronizer with async active-low reset and reset value 1. It is reusable for other asynchronous inputs.

Test Plan (BIT_WIDTH=16, DBIT=8, SB_TICK=16, s_tick every 4 clk unless stated):
- Frame 0xA5, correct stop bit -> one rx_done pulse, rx_dout=8'hA5, frame_err=0, parity_err=0; no further strobes while the line stays idle.
- rx low for 5 ticks, then high -> no rx_done; state back in IDLE; a following valid 0x3C frame decodes correctly.
- Frame 0x81 with stop bit driven 0 -> rx_done with rx_dout=8'h81 and frame_err=1. Next clean 0x7E frame -> frame_err=0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_done strobes, values 8'h00 then 8'hFF.
- rst_n pulsed low mid-DATA of 0x55 -> outputs go to 0 asynchronously, no rx_done. Next frame 0xC3 -> 8'hC3.
- With UART_RX_PARITY_EN, PARITY_ODD=0:
  - Frame 0x07 with parity bit 1 -> parity_err=0.
  - Same frame with parity bit 0 -> parity_err=1.
